// File: rtl/sparc_mem_ctrl_if.sv
// Bus bundle between the control unit and sparc_mem_ctrl.
// master: CU side (Enable/OpCode/MAR/MDR in); slave: memory side (MDR out, MFC, Busy, Last, Error).
interface sparc_mem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              Enable;
  logic [5:0]        OpCode;
  logic [ADDR_W-1:0] MAR_Address;
  logic [31:0]       MDR_DataIn;
  logic [31:0]       MDR_DataOut;
  logic              MFC;
  logic              Busy;
  logic              Last;
  logic              Error;

  modport master (
    output Enable, OpCode, MAR_Address, MDR_DataIn,
    input  MDR_DataOut, MFC, Busy, Last, Error
  );

  modport slave (
    input  Enable, OpCode, MAR_Address, MDR_DataIn,
    output MDR_DataOut, MFC, Busy, Last, Error
  );
endinterface

// File: rtl/sparc_mem_ctrl.sv
// Big-endian byte-addressed data memory with wait states, LDD/STD, SWAP.
// Ports: Clk, Reset_n (async low), bus (slave modport). Option: ALIGN_CHECK_EN.
module sparc_mem_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input logic            Clk,
  input logic            Reset_n,
  sparc_mem_ctrl_if.slave bus
);
  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WC    = 4'(WAIT_CYCLES);

  localparam logic [5:0] OP_LW   = 6'b000000;
  localparam logic [5:0] OP_LUB  = 6'b000001;
  localparam logic [5:0] OP_LUH  = 6'b000010;
  localparam logic [5:0] OP_LDD  = 6'b000011;
  localparam logic [5:0] OP_SW   = 6'b000100;
  localparam logic [5:0] OP_SB   = 6'b000101;
  localparam logic [5:0] OP_SH   = 6'b000110;
  localparam logic [5:0] OP_STD  = 6'b000111;
  localparam logic [5:0] OP_LSB  = 6'b001001;
  localparam logic [5:0] OP_LSH  = 6'b001010;
  localparam logic [5:0] OP_SWAP = 6'b001111;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [5:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       dout_q, dout_d;
  logic              beat_q, beat_d;
  logic              mfc_q, mfc_d;
  logic              busy_q, busy_d;
  logic              last_q, last_d;
  logic              err_q, err_d;

  logic [7:0]        mem [DEPTH];

  logic              is_ld, is_st, dbl, sgn, known, misal, bad;
  logic [2:0]        nb;
  logic [ADDR_W-1:0] ba [4];
  logic [7:0]        wb [4];
  logic [3:0]        we;
  logic [31:0]       rd_w, ld_val;

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    dbl   = 1'b0;
    sgn   = 1'b0;
    nb    = 3'd4;
    known = 1'b1;
    unique case (1'b1)
      (op_q == OP_LW):   is_ld = 1'b1;
      (op_q == OP_LUB):  begin is_ld = 1'b1; nb = 3'd1; end
      (op_q == OP_LUH):  begin is_ld = 1'b1; nb = 3'd2; end
      (op_q == OP_LDD):  begin is_ld = 1'b1; dbl = 1'b1; end
      (op_q == OP_SW):   is_st = 1'b1;
      (op_q == OP_SB):   begin is_st = 1'b1; nb = 3'd1; end
      (op_q == OP_SH):   begin is_st = 1'b1; nb = 3'd2; end
      (op_q == OP_STD):  begin is_st = 1'b1; dbl = 1'b1; end
      (op_q == OP_LSB):  begin is_ld = 1'b1; nb = 3'd1; sgn = 1'b1; end
      (op_q == OP_LSH):  begin is_ld = 1'b1; nb = 3'd2; sgn = 1'b1; end
      (op_q == OP_SWAP): begin is_ld = 1'b1; is_st = 1'b1; end
      default:           known = 1'b0;
    endcase
  end

`ifdef ALIGN_CHECK_EN
  always_comb begin
    misal = 1'b0;
    if (dbl)            misal = (addr_q[2:0] != 3'd0);
    else if (nb == 3'd2) misal = addr_q[0];
    else if (nb == 3'd4) misal = (addr_q[1:0] != 2'd0);
  end
`else
  assign misal = 1'b0;
`endif

  assign bad = !known || misal;

  // Byte lanes wrap modulo the memory size; lane 0 is the MSB (big-endian).
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ba[i] = addr_q + ADDR_W'(i);
    end
  end

  assign rd_w = {mem[ba[0]], mem[ba[1]], mem[ba[2]], mem[ba[3]]};

  always_comb begin
    ld_val = rd_w;
    if (nb == 3'd1)
      ld_val = sgn ? {{24{rd_w[31]}}, rd_w[31:24]} : {24'd0, rd_w[31:24]};
    else if (nb == 3'd2)
      ld_val = sgn ? {{16{rd_w[31]}}, rd_w[31:16]} : {16'd0, rd_w[31:16]};
  end

  // Store data is right-justified in MDR; the top stored byte lands at A.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      we[i] = 1'b0;
      wb[i] = 8'd0;
      if (i < int'(nb)) begin
        we[i] = (state_q == S_ACC) && !bad && is_st;
        wb[i] = 8'(data_q >> (8 * (int'(nb) - 1 - i)));
      end
    end
  end

  always_ff @(posedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[ba[i]] <= wb[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    beat_d  = beat_q;
    dout_d  = dout_q;
    mfc_d   = 1'b0;
    last_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.Enable) begin
          op_d    = bus.OpCode;
          addr_d  = bus.MAR_Address;
          data_d  = bus.MDR_DataIn;
          beat_d  = 1'b0;
          cnt_d   = WC;
          state_d = (WC == 4'd0) ? S_ACC : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_ACC;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACC: begin
        mfc_d = 1'b1;
        if (bad) begin
          err_d   = 1'b1;
          last_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          if (is_ld) dout_d = ld_val;
          if (dbl && !beat_q) begin
            // Beat 2 takes a fresh MDR word and restarts the wait states.
            beat_d  = 1'b1;
            addr_d  = addr_q + ADDR_W'(4);
            data_d  = bus.MDR_DataIn;
            cnt_d   = WC;
            state_d = (WC == 4'd0) ? S_ACC : S_WAIT;
          end else begin
            last_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 6'd0;
      addr_q  <= '0;
      data_q  <= 32'd0;
      dout_q  <= 32'd0;
      beat_q  <= 1'b0;
      mfc_q   <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      dout_q  <= dout_d;
      beat_q  <= beat_d;
      mfc_q   <= mfc_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus.MDR_DataOut = dout_q;
  assign bus.MFC         = mfc_q;
  assign bus.Busy        = busy_q;
  assign bus.Last        = last_q;
  assign bus.Error       = err_q;
endmodule

// File: tb/tb_sparc_mem_ctrl.sv
// Scoreboard bench for sparc_mem_ctrl: byte-array reference model, random ops.
// Ports: drives the bus master side; honours ALIGN_CHECK_EN when defined.
module tb_sparc_mem_ctrl;
  localparam int AW = 8;
  localparam int W  = 2;

  logic Clk = 1'b0;
  logic Reset_n = 1'b1;
  always #5 Clk = ~Clk;

  sparc_mem_ctrl_if #(.ADDR_W(AW)) bus ();

  sparc_mem_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  mm [256];
  logic [31:0] dout_m = 32'd0;
  logic [31:0] last_data = 32'd0;
  logic        last_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every MFC pops one expected beat.
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (bus.MFC) begin
        last_data = bus.MDR_DataOut;
        last_err  = bus.Error;
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_mfc: got MFC=1 expected no MFC");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("mfc_data", bus.MDR_DataOut, e.data);
          chk("mfc_last", {31'd0, bus.Last}, {31'd0, e.last});
          chk("mfc_err", {31'd0, bus.Error}, {31'd0, e.err});
        end
      end else if (bus.Last || bus.Error) begin
        n_tests++;
        n_fail++;
        $display("FAIL stray_flag: got Last=%b Error=%b expected 0 without MFC",
                 bus.Last, bus.Error);
      end
    end
  end

  // Reference model: applies an op to the byte array, queues expected beats.
  task automatic model(input logic [5:0] op, input logic [7:0] a,
                       input logic [31:0] d0, input logic [31:0] d1);
    int          nb;
    int          nbeat;
    bit          ld, st, dbl, sg, ok, mis;
    logic [7:0]  base;
    logic [31:0] word, v;
    nb = 4; ld = 0; st = 0; dbl = 0; sg = 0; ok = 1; mis = 0;
    case (op)
      6'd0:  ld = 1;
      6'd1:  begin ld = 1; nb = 1; end
      6'd2:  begin ld = 1; nb = 2; end
      6'd3:  begin ld = 1; dbl = 1; end
      6'd4:  st = 1;
      6'd5:  begin st = 1; nb = 1; end
      6'd6:  begin st = 1; nb = 2; end
      6'd7:  begin st = 1; dbl = 1; end
      6'd9:  begin ld = 1; nb = 1; sg = 1; end
      6'd10: begin ld = 1; nb = 2; sg = 1; end
      6'd15: begin ld = 1; st = 1; end
      default: ok = 0;
    endcase
`ifdef ALIGN_CHECK_EN
    if (dbl)          mis = (a % 8) != 0;
    else if (nb == 2) mis = (a % 2) != 0;
    else if (nb == 4) mis = (a % 4) != 0;
`endif
    if (!ok || mis) begin
      q.push_back('{data: dout_m, last: 1'b1, err: 1'b1});
      return;
    end
    nbeat = dbl ? 2 : 1;
    for (int b = 0; b < nbeat; b++) begin
      base = 8'(int'(a) + 4 * b);
      word = 32'd0;
      for (int i = 0; i < 4; i++) word = (word << 8) | 32'(mm[8'(base + i)]);
      if (ld) begin
        if (nb == 1)      v = sg ? 32'($signed(word[31:24])) : 32'(word[31:24]);
        else if (nb == 2) v = sg ? 32'($signed(word[31:16])) : 32'(word[31:16]);
        else              v = word;
        dout_m = v;
      end
      if (st) begin
        v = (b == 0) ? d0 : d1;
        for (int i = 0; i < nb; i++) mm[8'(base + i)] = 8'(v >> (8 * (nb - 1 - i)));
      end
      q.push_back('{data: dout_m, last: (b == nbeat - 1), err: 1'b0});
    end
  endtask

  // mode 0: plain; 1: extra Enable pulse while busy; 2: Enable held to the end.
  task automatic issue(input logic [5:0] op, input logic [7:0] a,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input int mode);
    int n;
    int first;
    bit done;
    model(op, a, d0, d1);
    bus.Enable = 1'b1;
    bus.OpCode = op;
    bus.MAR_Address = a;
    bus.MDR_DataIn = d0;
    @(posedge Clk);
    #1;
    if (mode != 2) bus.Enable = 1'b0;
    bus.MDR_DataIn = d1;
    chk("busy_after_accept", {31'd0, bus.Busy}, 32'd1);
    n = 0;
    first = -1;
    done = 0;
    while (!done && n < 100) begin
      @(negedge Clk);
      n++;
      if (mode == 1 && n == 1) bus.Enable = 1'b1;
      if (mode == 1 && n == 2) bus.Enable = 1'b0;
      if (bus.MFC && first < 0) first = n - 1;
      if (!bus.Busy) done = 1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got Busy=1 after %0d cycles expected 0", n);
    end
    bus.Enable = 1'b0;
    chk("latency", 32'(first), 32'(W + 1));
    #1;
  endtask

  logic [5:0]  ops [11] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5,
                            6'd6, 6'd7, 6'd9, 6'd10, 6'd15};
  logic [31:0] old30;

  initial begin
    bus.Enable = 1'b0;
    bus.OpCode = 6'd0;
    bus.MAR_Address = '0;
    bus.MDR_DataIn = 32'd0;
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_mfc", {31'd0, bus.MFC}, 32'd0);
    chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("rst_dout", bus.MDR_DataOut, 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 64; i++) issue(6'd4, 8'(i * 4), $urandom, 32'd0, 0);

    issue(6'd4, 8'h10, 32'hDEADBEEF, 32'd0, 0);
    issue(6'd0, 8'h10, 32'd0, 32'd0, 0);
    chk("t1_lw", last_data, 32'hDEADBEEF);

    issue(6'd5, 8'h12, 32'h00000055, 32'd0, 0);
    issue(6'd0, 8'h10, 32'd0, 32'd0, 0);
    chk("t2_lw", last_data, 32'hDEAD55EF);
    issue(6'd9, 8'h10, 32'd0, 32'd0, 0);
    chk("t2_lsb", last_data, 32'hFFFFFFDE);
    issue(6'd2, 8'h12, 32'd0, 32'd0, 0);
    chk("t2_luh", last_data, 32'h000055EF);

    issue(6'd7, 8'h20, 32'h11111111, 32'h22222222, 0);
    issue(6'd3, 8'h20, 32'd0, 32'd0, 0);
    chk("t3_ldd_beat2", last_data, 32'h22222222);

    issue(6'd15, 8'h20, 32'hCAFEF00D, 32'd0, 0);
    chk("t4_swap_old", last_data, 32'h11111111);
    issue(6'd0, 8'h20, 32'd0, 32'd0, 0);
    chk("t4_lw", last_data, 32'hCAFEF00D);

    issue(6'b111111, 8'h20, 32'h0BADF00D, 32'd0, 1);
    chk("t5_err", {31'd0, last_err}, 32'd1);
    issue(6'd0, 8'h20, 32'd0, 32'd0, 2);
    chk("t5_mem_kept", last_data, 32'hCAFEF00D);

    old30 = {mm[8'h30], mm[8'h31], mm[8'h32], mm[8'h33]};
    bus.Enable = 1'b1;
    bus.OpCode = 6'd4;
    bus.MAR_Address = 8'h30;
    bus.MDR_DataIn = ~old30;
    @(posedge Clk);
    #1 bus.Enable = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("t6_rst_mfc", {31'd0, bus.MFC}, 32'd0);
    chk("t6_rst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("t6_rst_dout", bus.MDR_DataOut, 32'd0);
    dout_m = 32'd0;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    issue(6'd0, 8'h30, 32'd0, 32'd0, 0);
    chk("t6_mem_kept", last_data, old30);
    issue(6'd0, 8'h31, 32'd0, 32'd0, 0);
`ifdef ALIGN_CHECK_EN
    chk("t6_misalign_err", {31'd0, last_err}, 32'd1);
`endif

    for (int k = 0; k < 150; k++) begin
      int idx;
      logic [5:0] op;
      idx = $urandom_range(0, 11);
      op = (idx == 11) ? 6'($urandom) : ops[idx];
      issue(op, 8'($urandom), $urandom, $urandom, $urandom_range(0, 2));
    end

    repeat (5) @(negedge Clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
